// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and state encoding for the instruction fetch sequencer.
package fetch_ctrl_pkg;

  localparam int unsigned DEFAULT_WORD_LEN = 32;
  localparam int unsigned PC_INC           = 4;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, runs the req/ack handshake with instruction
// memory, applies branch redirects and presents registered instruction/PC pairs.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned          WORD_LEN = DEFAULT_WORD_LEN,
  parameter logic [WORD_LEN-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branch_taken,
  input  logic [WORD_LEN-1:0] branch_target,
  input  logic                freeze,
  output logic                mem_req,
  output logic [WORD_LEN-1:0] mem_addr,
  input  logic                mem_ack,
  input  logic [WORD_LEN-1:0] mem_rdata,
  output logic                valid,
  output logic [WORD_LEN-1:0] instruction,
  output logic [WORD_LEN-1:0] PC
);

  fetch_state_e        state_q;
  logic [WORD_LEN-1:0] pc_q;
  logic [WORD_LEN-1:0] tgt_q;
  logic [WORD_LEN-1:0] hold_buf_q;
  logic [WORD_LEN-1:0] hold_pc_q;
  logic [WORD_LEN-1:0] instr_q;
  logic [WORD_LEN-1:0] pc_out_q;
  logic                valid_q;

  logic                ack;
  logic                out_ok;
  logic [WORD_LEN-1:0] pc_inc;

  // Gating with rst drops the request in the reset cycle itself.
  assign mem_req     = ~rst & (state_q != HOLD);
  assign mem_addr    = pc_q;
  assign valid       = valid_q;
  assign instruction = instr_q;
  assign PC          = pc_out_q;

  assign ack    = mem_ack & (state_q != HOLD);
  assign out_ok = ~valid_q | ~freeze;
  assign pc_inc = pc_q + WORD_LEN'(PC_INC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      hold_buf_q <= '0;
      hold_pc_q  <= '0;
      instr_q    <= '0;
      pc_out_q   <= '0;
      valid_q    <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (ack) begin
            if (branch_taken) begin
              pc_q    <= branch_target;
              valid_q <= 1'b0;
            end else if (out_ok) begin
              instr_q  <= mem_rdata;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_inc;
            end else begin
              hold_buf_q <= mem_rdata;
              hold_pc_q  <= pc_q;
              pc_q       <= pc_inc;
              state_q    <= HOLD;
            end
          end else if (branch_taken) begin
            tgt_q   <= branch_target;
            valid_q <= 1'b0;
            state_q <= SQUASH;
          end else if (!freeze) begin
            valid_q <= 1'b0;
          end
        end
        // The outstanding word belongs to the old path; only the newest target survives.
        SQUASH: begin
          valid_q <= 1'b0;
          if (ack) begin
            pc_q    <= branch_taken ? branch_target : tgt_q;
            state_q <= FETCH;
          end else if (branch_taken) begin
            tgt_q <= branch_target;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            valid_q <= 1'b0;
            pc_q    <= branch_target;
            state_q <= FETCH;
          end else if (!freeze) begin
            instr_q  <= hold_buf_q;
            pc_out_q <= hold_pc_q;
            valid_q  <= 1'b1;
            state_q  <= FETCH;
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule
